// File: rtl/calc_keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_keypad_pkg                                                            |
// | Key codes, scanner FSM states and the (row,col) -> key code map.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package calc_keypad_pkg;

  localparam logic [3:0] KEY_0   = 4'h0;
  localparam logic [3:0] KEY_1   = 4'h1;
  localparam logic [3:0] KEY_2   = 4'h2;
  localparam logic [3:0] KEY_3   = 4'h3;
  localparam logic [3:0] KEY_4   = 4'h4;
  localparam logic [3:0] KEY_5   = 4'h5;
  localparam logic [3:0] KEY_6   = 4'h6;
  localparam logic [3:0] KEY_7   = 4'h7;
  localparam logic [3:0] KEY_8   = 4'h8;
  localparam logic [3:0] KEY_9   = 4'h9;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } kp_state_t;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_0;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_ADD;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_SUB;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_MUL;
      4'b11_00: code = KEY_CLR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_EQ;
      default:  code = KEY_DIV;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_keypad_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_keypad_if                                                             |
// | Valid/ready key code channel from the scanner to the calculator core.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface calc_keypad_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_valid, input  key_ready);
  modport slave  (input  key_code, input  key_valid, output key_ready);
endinterface
`default_nettype wire

// File: rtl/calc_row_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_row_sync                                                              |
// | Two-flop synchronizer for the asynchronous keypad rows, idles high.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module calc_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_async,
  output logic [3:0] row_sync
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 4'hF;
      r_sync <= 4'hF;
    end else begin
      r_meta <= row_async;
      r_sync <= r_meta;
    end
  end

  assign row_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/calc_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_keypad_scanner                                                        |
// | 4x4 keypad scan + debounce, one key code per press on a valid/ready slot.  |
// | Optional auto-repeat while held: define KEYPAD_REPEAT_EN.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module calc_keypad_scanner
  import calc_keypad_pkg::*;
#(
  parameter int CLK_DIV       = 1000,
  parameter int DEBOUNCE_CNT  = 4,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    row_in,
  output logic [3:0]    col_out,
  calc_keypad_if.master key_if
);

  localparam int               c_div_w    = $clog2(CLK_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [3:0]       c_deb_cnt  = 4'(DEBOUNCE_CNT);

  if (CLK_DIV < 4 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("calc_keypad_scanner: parameter out of range");
  end

  logic [c_div_w-1:0] r_div;
  logic               w_tick;
  logic [3:0]         w_rows;
  logic               w_any_low;
  logic [1:0]         w_low_row;

  kp_state_t  r_state;
  logic [1:0] r_col;
  logic [3:0] r_col_out;
  logic [1:0] r_row;
  logic [3:0] r_stable;
  logic [3:0] r_rel;
  logic [3:0] r_key_code;
  logic       r_key_valid;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] c_rep_delay  = 16'(REPEAT_DELAY);
  localparam logic [15:0] c_rep_period = 16'(REPEAT_PERIOD);
  logic [15:0] r_hold;
  logic        r_first;
`endif

  calc_row_sync u_row_sync (
    .clk       (clk),
    .rst       (rst),
    .row_async (row_in),
    .row_sync  (w_rows)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (r_div == c_div_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick    = (r_div == c_div_last);
  assign w_any_low = ~&w_rows;

  always_comb begin
    w_low_row = 2'd3;
    if      (!w_rows[0]) w_low_row = 2'd0;
    else if (!w_rows[1]) w_low_row = 2'd1;
    else if (!w_rows[2]) w_low_row = 2'd2;
  end

  // The column index and the one-hot strobe advance together so col_out is a clean register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SCAN;
      r_col       <= 2'd0;
      r_col_out   <= 4'b1110;
      r_row       <= 2'd0;
      r_stable    <= 4'd0;
      r_rel       <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_hold      <= 16'd0;
      r_first     <= 1'b1;
`endif
    end else begin
      if (r_key_valid && key_if.key_ready) begin
        r_key_valid <= 1'b0;
      end
      case (r_state)
        SCAN: begin
          if (w_tick) begin
            if (w_any_low) begin
              r_row    <= w_low_row;
              r_stable <= 4'd1;
              r_state  <= (c_deb_cnt == 4'd1) ? EMIT : DEBOUNCE;
            end else begin
              r_col     <= r_col + 2'd1;
              r_col_out <= {r_col_out[2:0], r_col_out[3]};
            end
          end
        end
        DEBOUNCE: begin
          if (w_tick) begin
            if (!w_rows[r_row]) begin
              r_stable <= r_stable + 4'd1;
              if (r_stable + 4'd1 == c_deb_cnt) begin
                r_state <= EMIT;
              end
            end else begin
              r_state   <= SCAN;
              r_col     <= r_col + 2'd1;
              r_col_out <= {r_col_out[2:0], r_col_out[3]};
            end
          end
        end
        EMIT: begin
          if (!r_key_valid) begin
            r_key_code  <= key_map(r_row, r_col);
            r_key_valid <= 1'b1;
            r_rel       <= 4'd0;
            r_state     <= WAIT_RELEASE;
`ifdef KEYPAD_REPEAT_EN
            r_hold      <= 16'd0;
            r_first     <= 1'b1;
`endif
          end
        end
        WAIT_RELEASE: begin
          if (w_tick) begin
            if (w_rows[r_row]) begin
`ifdef KEYPAD_REPEAT_EN
              r_hold  <= 16'd0;
              r_first <= 1'b1;
`endif
              if (r_rel + 4'd1 == c_deb_cnt) begin
                r_rel     <= 4'd0;
                r_state   <= SCAN;
                r_col     <= r_col + 2'd1;
                r_col_out <= {r_col_out[2:0], r_col_out[3]};
              end else begin
                r_rel <= r_rel + 4'd1;
              end
            end else begin
              r_rel <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
              // A repeat instant with the slot still full is dropped, not deferred.
              if (r_hold + 16'd1 == (r_first ? c_rep_delay : c_rep_period)) begin
                r_hold  <= 16'd0;
                r_first <= 1'b0;
                if (!r_key_valid) begin
                  r_key_valid <= 1'b1;
                end
              end else begin
                r_hold <= r_hold + 16'd1;
              end
`endif
            end
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign col_out          = r_col_out;
  assign key_if.key_code  = r_key_code;
  assign key_if.key_valid = r_key_valid;

endmodule
`default_nettype wire

// File: tb/tb_calc_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_calc_keypad_scanner                                                     |
// | Scoreboard bench: a keypad model drives rows, accepted codes are checked.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_calc_keypad_scanner;
  import calc_keypad_pkg::*;

  localparam int CLK_DIV       = 4;
  localparam int DEBOUNCE_CNT  = 3;
  localparam int REPEAT_DELAY  = 8;
  localparam int REPEAT_PERIOD = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_TICKS = 5;
`else
  localparam int HOLD_TICKS = 40;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  calc_keypad_if kif ();

  logic       press_en   = 1'b0;
  logic [3:0] press_rows = 4'h0;
  int         press_col  = 0;

  int         n_pass  = 0;
  int         n_total = 0;
  int         cyc     = 0;
  logic [3:0] exp_q[$];
  int         hs_cyc[$];
  logic [3:0] exp_code;

  calc_keypad_scanner #(
    .CLK_DIV       (CLK_DIV),
    .DEBOUNCE_CNT  (DEBOUNCE_CNT),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .key_if  (kif.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad model: pressed rows pull low only while their column is strobed.
  always_comb row_in = (press_en && col_out[press_col[1:0]] == 1'b0) ? ~press_rows : 4'hF;

  always @(negedge clk) begin
    if (!rst && kif.key_valid && kif.key_ready) begin
      n_total++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        $display("FAIL handshake: got unexpected key_code=%h, required none", kif.key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (kif.key_code !== exp_code)
          $display("FAIL key_code: got %h, required %h", kif.key_code, exp_code);
        else
          n_pass++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] col, input int budget);
    int t = 0;
    while (col_out !== col && t < budget) begin step(1); t++; end
  endtask

  task automatic test_reset;
    logic [3:0] exp_col;
    rst = 1'b1; kif.key_ready = 1'b0; press_en = 1'b0;
    step(2);
    n_total++; if (col_out !== 4'b1110) $display("FAIL reset_col: got %b, required 1110", col_out); else n_pass++;
    n_total++; if (kif.key_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", kif.key_valid); else n_pass++;
    n_total++; if (kif.key_code !== 4'h0) $display("FAIL reset_code: got %h, required 0", kif.key_code); else n_pass++;
    @(negedge clk) rst = 1'b0;
    step(1);
    wait_col(4'b1101, 4 * CLK_DIV);
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      exp_col = 4'b0001;
      exp_col = ~(exp_col << ((1 + i / CLK_DIV) % 4));
      n_total++;
      if (col_out !== exp_col) $display("FAIL scan_col[%0d]: got %b, required %b", i, col_out, exp_col);
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_press_5;
    int t = 0;
    int lo, hi;
    kif.key_ready = 1'b1;
    exp_q.push_back(4'h5);
    press_rows = 4'b0010; press_col = 1; press_en = 1'b1;
    while (exp_q.size() != 0 && t < 40 * CLK_DIV) begin step(1); t++; end
    n_total++; if (exp_q.size() != 0) $display("FAIL press5_delivered: got %0d pending, required 0", exp_q.size()); else n_pass++;
    step(HOLD_TICKS * CLK_DIV);
    press_en = 1'b0;
    // Sync delay of 2, then up to one dwell to the first tick, then DEBOUNCE_CNT-1 more ticks.
    lo = 3 + (DEBOUNCE_CNT - 1) * CLK_DIV;
    hi = lo + CLK_DIV - 1;
    t = 0;
    while (col_out === 4'b1101 && t < 10 * CLK_DIV) begin step(1); t++; end
    n_total++; if (col_out !== 4'b1011) $display("FAIL press5_resume_col: got %b, required 1011", col_out); else n_pass++;
    n_total++; if (t < lo || t > hi) $display("FAIL press5_release_time: got %0d cycles, required %0d..%0d", t, lo, hi); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL press5_count: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_bounce;
    kif.key_ready = 1'b1;
    wait_col(4'b1101, 8 * CLK_DIV);
    press_rows = 4'b0001; press_col = 2; press_en = 1'b1;
    wait_col(4'b1011, 2 * CLK_DIV);
    step(2 * CLK_DIV);
    press_en = 1'b0;
    step(CLK_DIV - 1);
    n_total++; if (col_out !== 4'b1011) $display("FAIL bounce_freeze: got %b, required 1011", col_out); else n_pass++;
    step(1);
    n_total++; if (col_out !== 4'b0111) $display("FAIL bounce_advance: got %b, required 0111", col_out); else n_pass++;
    n_total++; if (kif.key_valid !== 1'b0) $display("FAIL bounce_valid: got %b, required 0", kif.key_valid); else n_pass++;
  endtask

  task automatic test_hold_hash;
    int t = 0;
    kif.key_ready = 1'b0;
    exp_q.push_back(4'hF);
    press_rows = 4'b1000; press_col = 2; press_en = 1'b1;
    while (kif.key_valid !== 1'b1 && t < 40 * CLK_DIV) begin step(1); t++; end
    n_total++; if (kif.key_code !== 4'hF) $display("FAIL hash_code: got %h, required f", kif.key_code); else n_pass++;
    for (int i = 0; i < 100; i++) begin
      n_total++;
      if (kif.key_valid !== 1'b1 || kif.key_code !== 4'hF)
        $display("FAIL hash_hold[%0d]: got valid=%b code=%h, required valid=1 code=f", i, kif.key_valid, kif.key_code);
      else n_pass++;
      step(1);
    end
    press_en = 1'b0;
    step((DEBOUNCE_CNT + 3) * CLK_DIV);
    kif.key_ready = 1'b1;
    step(1);
    kif.key_ready = 1'b0;
    n_total++; if (kif.key_valid !== 1'b0) $display("FAIL hash_accept: got valid=%b, required 0", kif.key_valid); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL hash_count: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_two_rows;
    int t = 0;
    kif.key_ready = 1'b1;
    exp_q.push_back(4'h1);
    press_rows = 4'b0011; press_col = 0; press_en = 1'b1;
    while (exp_q.size() != 0 && t < 40 * CLK_DIV) begin step(1); t++; end
    n_total++; if (exp_q.size() != 0) $display("FAIL two_rows_delivered: got %0d pending, required 0", exp_q.size()); else n_pass++;
    press_en = 1'b0;
    step((DEBOUNCE_CNT + 3) * CLK_DIV);
  endtask

  task automatic test_reset_async;
    int t = 0;
    kif.key_ready = 1'b0;
    press_rows = 4'b0010; press_col = 0; press_en = 1'b1;
    while (kif.key_valid !== 1'b1 && t < 40 * CLK_DIV) begin step(1); t++; end
    n_total++; if (kif.key_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b, required 1", kif.key_valid); else n_pass++;
    rst = 1'b1;
    #2;
    n_total++; if (kif.key_valid !== 1'b0) $display("FAIL arst_valid: got %b, required 0", kif.key_valid); else n_pass++;
    n_total++; if (col_out !== 4'b1110) $display("FAIL arst_col: got %b, required 1110", col_out); else n_pass++;
    n_total++; if (kif.key_code !== 4'h0) $display("FAIL arst_code: got %h, required 0", kif.key_code); else n_pass++;
    press_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    step(2);
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat;
    int t = 0;
    kif.key_ready = 1'b1;
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(4'h7);
    press_rows = 4'b0100; press_col = 0; press_en = 1'b1;
    while (exp_q.size() != 0 && t < 100 * CLK_DIV) begin step(1); t++; end
    press_en = 1'b0;
    step((DEBOUNCE_CNT + 6) * CLK_DIV);
    n_total++;
    if (hs_cyc.size() != 4) begin
      $display("FAIL repeat_count: got %0d codes, required 4", hs_cyc.size());
    end else begin
      n_pass++;
      // First code leaves via EMIT one cycle after its tick; repeats load on the tick itself.
      n_total++;
      if (hs_cyc[1] - hs_cyc[0] != REPEAT_DELAY * CLK_DIV - 1)
        $display("FAIL repeat_delay: got %0d cycles, required %0d", hs_cyc[1] - hs_cyc[0], REPEAT_DELAY * CLK_DIV - 1);
      else n_pass++;
      for (int i = 2; i < 4; i++) begin
        n_total++;
        if (hs_cyc[i] - hs_cyc[i-1] != REPEAT_PERIOD * CLK_DIV)
          $display("FAIL repeat_period[%0d]: got %0d cycles, required %0d", i, hs_cyc[i] - hs_cyc[i-1], REPEAT_PERIOD * CLK_DIV);
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    kif.key_ready = 1'b0;
    test_reset();
    test_press_5();
    test_bounce();
    test_hold_hash();
    test_two_rows();
    test_reset_async();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/calc_keypad_scanner.md
Name: calc_keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces presses and emits one 4-bit key code per press over a valid/ready handshake.
- Sits directly upstream of the calculator core inside tt_um_intro_ii_calculator.
- Rows arrive on ui_in[3:0]; columns are driven on uo_out/uio.
- The top level derives rst from ~rst_n.

Parameters:
- CLK_DIV, 1000: clocks per column dwell; the sample tick fires on the last cycle of each dwell. Minimum 4.
- DEBOUNCE_CNT, 4: consecutive sample ticks required to accept a press or a release. Range 1..15.
- REPEAT_DELAY, 64: ticks held before the first auto-repeat. Used only with KEYPAD_REPEAT_EN.
- REPEAT_PERIOD, 16: ticks between subsequent repeats. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- row_in  in  4  keypad rows, active-low (external pull-ups), asynchronous
- col_out  out  4  column strobe, active-low one-hot
- key_code  out  4  code of the accepted key
- key_valid  out  1  key_code is valid; held until accepted
- key_ready  in  1  consumer accepts the key when key_valid && key_ready

Behaviour:
- Reset values:
  - col_out=4'b1110 (column 0)
  - key_valid=0, key_code=0
  - FSM=SCAN; all counters 0
- Reset is asynchronous and may assert in any state. It clears everything immediately; a pending key is lost.
- row_in passes through a 2-flop synchronizer. All decisions use the synchronized rows, sampled only on the tick.
- Key map (row,col -> code):
  - r0: 1,2,3,A = 0x1,0x2,0x3,0xA
  - r1: 4,5,6,B = 0x4,0x5,0x6,0xB
  - r2: 7,8,9,C = 0x7,0x8,0x9,0xC
  - r3: *,0,#,D = 0xE,0x0,0xF,0xD
- Divider counts 0..CLK_DIV-1 continuously; tick is asserted when the count equals CLK_DIV-1.
- SCAN:
  - On a tick with no row low: column advances 0->1->2->3->0, and col_out changes the following cycle.
  - On a tick with any row low: latch the candidate (lowest-index low row, current column), set stable=1, go to DEBOUNCE. The column freezes.
- DEBOUNCE:
  - On each tick, if the candidate row is still low, stable++.
  - If the candidate row is high, go to SCAN and advance the column.
  - When stable reaches DEBOUNCE_CNT, go to EMIT. For DEBOUNCE_CNT=1, the detection tick goes straight to EMIT.
- EMIT: if key_valid=0, load key_code from the map and set key_valid=1 on the next edge, then go to WAIT_RELEASE. Otherwise stay in EMIT until the slot is free.
- WAIT_RELEASE:
  - The column stays frozen.
  - Each tick with the candidate row high does rel++; a tick with it low clears rel.
  - At rel==DEBOUNCE_CNT, go to SCAN and advance the column.
  - Other keys pressed meanwhile are ignored.
- Output slot:
  - key_valid falls on the edge after valid&&ready.
  - key_code is stable while key_valid=1.
  - A new load and an acceptance in the same cycle is impossible, because EMIT waits for key_valid=0.
- No auto-repeat: exactly one code per physical press.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In WAIT_RELEASE, a hold counter counts ticks with the row low.
  - At REPEAT_DELAY, and then every REPEAT_PERIOD ticks after that, the same code is loaded if key_valid=0.
  - If the slot is full at a repeat instant, that repeat is skipped, not queued.
  - The counter clears on release.
- Undefined: no repeat logic is synthesized; REPEAT_* parameters are ignored.

Decomposition:
- Package calc_keypad_pkg:
  - key code localparams (KEY_0..KEY_9, KEY_ADD=0xA, KEY_SUB=0xB, KEY_MUL=0xC, KEY_DIV=0xD, KEY_CLR=0xE, KEY_EQ=0xF)
  - FSM state typedef {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE}
  - map function (row,col)->code
- One sub-module, calc_row_sync: 2-flop, 4-bit synchronizer with reset to 4'b1111.

Test Plan (CLK_DIV=4, DEBOUNCE_CNT=3 unless noted):
- Reset -> col_out=1110, key_valid=0, key_code=0. With no rows low, col_out cycles 1110,1101,1011,0111, each held 4 clocks.
- Hold row1 low whenever col1 is driven, key_ready=1, held 40 ticks, then release -> exactly one key_valid pulse with key_code=0x5. After 3 high ticks, scanning resumes at col2 (col_out=1011).
- Row0 low for 2 ticks on col2, then high -> no key_valid; FSM back in SCAN, column advances to col3.
- key_ready=0, press '#' (row3, col2) -> key_valid=1, key_code=0xF, stable for 100 cycles. Pulse key_ready one cycle -> key_valid=0 on the next edge.
- Rows 0 and 1 both low on col0 -> key_code=0x1.
- Assert rst during WAIT_RELEASE with key_valid=1 -> key_valid=0 and col_out=1110 without waiting for a clk edge.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4: hold '7', key_ready=1 -> codes 0x7 at the debounce point, then 8 ticks later, then every 4 ticks until release.
